// File: rtl/mem_responder.sv
// Memory-side responder: registered read/write servicing of an internal word array
// with programmable read latency. Optional MEM_WRITE_PROTECT_EN blocks writes to [0, PROTECT_TOP].
module mem_responder #(
  parameter int unsigned                 ADDR_WIDTH   = 8,
  parameter int unsigned                 DATA_WIDTH   = 16,
  parameter int unsigned                 READ_LATENCY = 2,
  parameter logic [ADDR_WIDTH-1:0]       PROTECT_TOP  = 'h0F
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_address_bus,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [DATA_WIDTH-1:0] i_data_bus,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  output logic                  o_mem_ready,
  output logic                  o_mem_busy,
  output logic                  o_mem_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_d;
  logic                  busy_d;
  logic                  err_d;
  logic                  data_load;
  logic                  mem_we;
  logic                  in_protect_range;
  logic                  protect_en;
  logic                  wr_blocked;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  assign in_protect_range = (i_address_bus <= PROTECT_TOP);

`ifdef MEM_WRITE_PROTECT_EN
  assign protect_en = 1'b1;
`else
  assign protect_en = 1'b0;
`endif

  assign wr_blocked = protect_en & in_protect_range;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    err_d     = o_mem_err;
    data_load = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_mem_write) begin
          // write wins over a simultaneous read; the conflict is flagged
          mem_we  = ~wr_blocked;
          ready_d = 1'b1;
          state_d = RESP;
          if (i_mem_read || wr_blocked) begin
            err_d = 1'b1;
          end
        end else if (i_mem_read) begin
          addr_d  = i_address_bus;
          cnt_d   = 4'(READ_LATENCY - 1);
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          data_load = 1'b1;
          ready_d   = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      o_data_bus  <= '0;
      o_mem_ready <= 1'b0;
      o_mem_busy  <= 1'b0;
      o_mem_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      o_mem_ready <= ready_d;
      o_mem_busy  <= busy_d;
      o_mem_err   <= err_d;
      if (data_load) begin
        o_data_bus <= mem[addr_q];
      end
    end
  end

  // array is not cleared by reset, so a write accepted with reset low always lands
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) begin
      mem[i_address_bus] <= i_data_bus;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (READ_LATENCY = 2).
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int n_tests;
  int n_fail;

  mem_responder #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (16),
    .READ_LATENCY(2),
    .PROTECT_TOP (8'h0F)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_address_bus(addr),
    .i_mem_read   (rd),
    .i_mem_write  (wr),
    .i_data_bus   (wdata),
    .o_data_bus   (rdata),
    .o_mem_ready  (ready),
    .o_mem_busy   (busy),
    .o_mem_err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    int n;
    wr = 1'b1; addr = a; wdata = d; n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 20);
    wr = 1'b0;
    if (!ready) check("wr_timeout", 32'(ready), 32'd1);
    tick();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [15:0] d);
    int n;
    rd = 1'b1; addr = a;
    tick();
    rd = 1'b0; n = 1;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (!ready) check("rd_timeout", 32'(ready), 32'd1);
    d = rdata;
    tick();
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] old05;
    int n;
    int rdy_cnt;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    tick(); tick();
    check("rst_data",  32'(rdata), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_err",   32'(err),   32'h0);
    rst = 1'b0;
    tick();

    // write A5C3 @ 20: ready at the acceptance edge, busy for the RESP cycle
    wr = 1'b1; addr = 8'h20; wdata = 16'hA5C3;
    tick();
    wr = 1'b0;
    check("wr_ready_e0", 32'(ready), 32'd1);
    check("wr_busy_e0",  32'(busy),  32'd1);
    tick();
    check("wr_ready_e1", 32'(ready), 32'd0);
    check("wr_busy_e1",  32'(busy),  32'd0);

    // read 20 with latency 2, cycle by cycle
    rd = 1'b1; addr = 8'h20;
    tick();
    rd = 1'b0;
    check("rd_ready_e0", 32'(ready), 32'd0);
    check("rd_busy_e0",  32'(busy),  32'd1);
    tick();
    check("rd_ready_e1", 32'(ready), 32'd0);
    check("rd_busy_e1",  32'(busy),  32'd1);
    tick();
    check("rd_ready_e2", 32'(ready), 32'd1);
    check("rd_data_e2",  32'(rdata), 32'hA5C3);
    check("rd_busy_e2",  32'(busy),  32'd1);
    tick();
    check("rd_ready_e3", 32'(ready), 32'd0);
    check("rd_busy_e3",  32'(busy),  32'd0);
    check("rd_hold_e3",  32'(rdata), 32'hA5C3);

    // back-to-back writes held/re-issued: ready pulses two cycles apart
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 8'h30 + 8'(i); wdata = 16'h1000 + 16'(i);
      n = 0;
      do begin
        tick();
        n++;
      end while (!ready && n < 20);
      check($sformatf("b2b_gap_%0d", i), 32'(n), (i == 0) ? 32'd1 : 32'd2);
    end
    wr = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      do_read(8'h30 + 8'(i), d);
      check($sformatf("b2b_rb_%0d", i), 32'(d), 32'h1000 + 32'(i));
    end
    check("no_err_yet", 32'(err), 32'd0);

    // simultaneous read+write: write performed, sticky error
    rd = 1'b1; wr = 1'b1; addr = 8'h40; wdata = 16'h1234;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("rw_ready", 32'(ready), 32'd1);
    check("rw_err",   32'(err),   32'd1);
    tick();
    do_read(8'h40, d);
    check("rw_data",      32'(d),   32'h1234);
    check("rw_err_stick", 32'(err), 32'd1);

    // address and write strobe changes during READ_WAIT are ignored
    do_write(8'h21, 16'h5A5A);
    rd = 1'b1; addr = 8'h20;
    tick();
    rd = 1'b0; addr = 8'h21; wr = 1'b1; wdata = 16'hBEEF;
    n = 1;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    wr = 1'b0;
    check("latch_ready", 32'(ready), 32'd1);
    check("latch_data",  32'(rdata), 32'hA5C3);
    tick();
    do_read(8'h21, d);
    check("latch_21_kept", 32'(d),   32'h5A5A);
    check("err_still_set", 32'(err), 32'd1);

    // reset in the first READ_WAIT cycle aborts the read
    rd = 1'b1; addr = 8'h30;
    tick();
    rd = 1'b0; rst = 1'b1;
    tick();
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_err",   32'(err),   32'd0);
    check("abort_data",  32'(rdata), 32'h0);
    rst = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ready) rdy_cnt++;
    end
    check("abort_no_pulse", 32'(rdy_cnt), 32'd0);
    do_read(8'h20, d);
    check("abort_mem_kept", 32'(d), 32'hA5C3);

    // write to a low address: blocked and flagged only with protection enabled
    do_read(8'h05, old05);
    wr = 1'b1; addr = 8'h05; wdata = 16'hFFFF;
    tick();
    wr = 1'b0;
    check("prot_ready", 32'(ready), 32'd1);
`ifdef MEM_WRITE_PROTECT_EN
    check("prot_err", 32'(err), 32'd1);
    tick();
    do_read(8'h05, d);
    check("prot_data", 32'(d), 32'(old05));
`else
    check("prot_err", 32'(err), 32'd0);
    tick();
    do_read(8'h05, d);
    check("prot_data", 32'(d), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
